// File: rtl/huffman_gen.sv
// -----------------------------------------------------------------------------
// huffman_gen
// Histograms a stream of grey-level symbols 1..NSYM, reports the counts, then
// builds a Huffman code by repeated two-minimum merging and presents a
// per-symbol code/mask pair. Frames may follow each other without a reset.
//
// Optional feature macro: HUFF_SKIP_ZERO_EN
//   defined   : zero-count symbols are left out of the merge (HC=0, M=0); a lone
//               non-zero symbol gets a 1-bit code 0.
//   undefined : every symbol takes part in the merge, zero counts included.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   gray_valid in   gray_data valid this cycle
//   gray_data  in   symbol value; 0 or > NSYM is ignored
//   CNT_valid  out  one-cycle pulse, CNT final
//   CNT        out  count of symbol s at [s*CNT_W-1 -: CNT_W]
//   code_valid out  level, HC/M final
//   HC         out  code of symbol s (read from bit len-1 down to 0)
//   M          out  mask of symbol s, (1<<len_s)-1
// -----------------------------------------------------------------------------
module huffman_gen #(
    parameter int NSYM   = 6,
    parameter int CNT_W  = 8,
    parameter int CODE_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gray_valid,
    input  logic [7:0]             gray_data,
    output logic                   CNT_valid,
    output logic [NSYM*CNT_W-1:0]  CNT,
    output logic                   code_valid,
    output logic [NSYM*CODE_W-1:0] HC,
    output logic [NSYM*CODE_W-1:0] M
);

    localparam int ID_W  = 3;
    localparam int NA_W  = 4;
    // Sum of up to eight saturated counts cannot overflow three extra bits.
    localparam int SUM_W = CNT_W + 3;
    localparam int LEN_W = $clog2(CODE_W + 1);

    typedef enum logic [2:0] {
        COUNT  = 3'd0,
        REPORT = 3'd1,
        SEL1   = 3'd2,
        SEL2   = 3'd3,
        MERGE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                  state_q;
    logic                    seen_q;
    logic                    cnt_valid_q;
    logic                    code_valid_q;
    logic [CNT_W-1:0]        cnt_q  [NSYM];
    logic [SUM_W-1:0]        sum_q  [NSYM];
    logic [ID_W-1:0]         grp_q  [NSYM];
    logic [CODE_W-1:0]       code_q [NSYM];
    logic [LEN_W-1:0]        len_q  [NSYM];
    logic [NSYM-1:0]         act_q;
    logic [NA_W-1:0]         nact_q;
    logic [ID_W-1:0]         sel_a_q;
    logic [ID_W-1:0]         sel_b_q;

    logic [NSYM-1:0]         act_init_s;
    logic [NA_W-1:0]         nact_s;
    logic [ID_W-1:0]         pick_s;
    logic [SUM_W-1:0]        best_s;
    logic                    found_s;
    logic                    take_s;
    logic [SUM_W-1:0]        sum_ab_s;
    logic [ID_W-1:0]         merge_id_s;
    logic [ID_W-1:0]         drop_id_s;

    // Which symbols open a group at REPORT, and how many groups that makes.
    always_comb begin
        act_init_s = '0;
        nact_s     = '0;
        for (int i = 0; i < NSYM; i++) begin
`ifdef HUFF_SKIP_ZERO_EN
            act_init_s[i] = (cnt_q[i] != '0);
`else
            act_init_s[i] = 1'b1;
`endif
            nact_s = nact_s + NA_W'(act_init_s[i]);
        end
    end

    // Minimum-count active group; "<=" while scanning upward lets the larger id
    // win a tie. In SEL2 the group already chosen as A is excluded.
    always_comb begin
        pick_s  = '0;
        best_s  = '1;
        found_s = 1'b0;
        take_s  = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            take_s  = act_q[i]
                      && !((state_q == SEL2) && (ID_W'(i) == sel_a_q))
                      && (!found_s || (sum_q[i] <= best_s));
            best_s  = take_s ? sum_q[i] : best_s;
            pick_s  = take_s ? ID_W'(i) : pick_s;
            found_s = found_s | take_s;
        end
    end

    // Merged count and the surviving / retired ids for the MERGE step.
    always_comb begin
        sum_ab_s = '0;
        for (int i = 0; i < NSYM; i++) begin
            sum_ab_s = sum_ab_s
                       + (((ID_W'(i) == sel_a_q) || (ID_W'(i) == sel_b_q)) ? sum_q[i] : SUM_W'(0));
        end
        merge_id_s = (sel_a_q < sel_b_q) ? sel_a_q : sel_b_q;
        drop_id_s  = (sel_a_q < sel_b_q) ? sel_b_q : sel_a_q;
    end

    // Control FSM with histogram, group table and code/length registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COUNT;
            seen_q       <= 1'b0;
            cnt_valid_q  <= 1'b0;
            code_valid_q <= 1'b0;
            act_q        <= '0;
            nact_q       <= '0;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            for (int i = 0; i < NSYM; i++) begin
                cnt_q[i]  <= '0;
                sum_q[i]  <= '0;
                grp_q[i]  <= ID_W'(i);
                code_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else begin
            cnt_valid_q <= 1'b0;
            case (state_q)
                COUNT: begin
                    if (gray_valid) begin
                        seen_q <= 1'b1;
                        for (int i = 0; i < NSYM; i++) begin
                            if ((gray_data == 8'(i + 1)) && (cnt_q[i] != '1)) begin
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                            end
                        end
                    end else if (seen_q) begin
                        seen_q      <= 1'b0;
                        cnt_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end
                end
                REPORT: begin
                    act_q  <= act_init_s;
                    nact_q <= nact_s;
                    for (int i = 0; i < NSYM; i++) begin
                        sum_q[i]  <= SUM_W'(cnt_q[i]);
                        grp_q[i]  <= ID_W'(i);
                        code_q[i] <= '0;
                        // A lone active symbol still needs a 1-bit code.
                        len_q[i]  <= ((nact_s == NA_W'(1)) && act_init_s[i]) ? LEN_W'(1) : LEN_W'(0);
                    end
                    if (nact_s <= NA_W'(1)) begin
                        code_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        state_q <= SEL1;
                    end
                end
                SEL1: begin
                    sel_a_q <= pick_s;
                    state_q <= SEL2;
                end
                SEL2: begin
                    sel_b_q <= pick_s;
                    state_q <= MERGE;
                end
                MERGE: begin
                    for (int i = 0; i < NSYM; i++) begin
                        if (grp_q[i] == sel_a_q) begin
                            code_q[i] <= code_q[i] | (CODE_W'(1) << len_q[i]);
                            len_q[i]  <= len_q[i] + LEN_W'(1);
                            grp_q[i]  <= merge_id_s;
                        end else if (grp_q[i] == sel_b_q) begin
                            code_q[i] <= code_q[i] & ~(CODE_W'(1) << len_q[i]);
                            len_q[i]  <= len_q[i] + LEN_W'(1);
                            grp_q[i]  <= merge_id_s;
                        end
                        if (ID_W'(i) == merge_id_s) begin
                            sum_q[i] <= sum_ab_s;
                        end
                        if (ID_W'(i) == drop_id_s) begin
                            act_q[i] <= 1'b0;
                        end
                    end
                    nact_q <= nact_q - NA_W'(1);
                    if (nact_q == NA_W'(2)) begin
                        code_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        state_q <= SEL1;
                    end
                end
                DONE: begin
                    // A new sample starts the next frame and is itself counted.
                    if (gray_valid) begin
                        seen_q       <= 1'b1;
                        code_valid_q <= 1'b0;
                        state_q      <= COUNT;
                        for (int i = 0; i < NSYM; i++) begin
                            cnt_q[i]  <= (gray_data == 8'(i + 1)) ? CNT_W'(1) : CNT_W'(0);
                            code_q[i] <= '0;
                            len_q[i]  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= COUNT;
                end
            endcase
        end
    end

    // Output packing; codes and masks are only shown once the code is final.
    always_comb begin
        CNT = '0;
        HC  = '0;
        M   = '0;
        for (int i = 0; i < NSYM; i++) begin
            CNT[i*CNT_W +: CNT_W] = cnt_q[i];
            HC[i*CODE_W +: CODE_W] = code_valid_q ? code_q[i] : CODE_W'(0);
            M[i*CODE_W +: CODE_W]  = code_valid_q ? ~({CODE_W{1'b1}} << len_q[i]) : CODE_W'(0);
        end
    end

    assign CNT_valid  = cnt_valid_q;
    assign code_valid = code_valid_q;

endmodule

// File: tb/tb_huffman_gen.sv
// -----------------------------------------------------------------------------
// tb_huffman_gen
// Directed bench for huffman_gen. Three instances: d0 NSYM=4 (basic code,
// back-to-back frames, reset mid-operation), d1 NSYM=2 (tie-break), d2 NSYM=4
// with CNT_W=4 (ignored values and saturation). Inputs are driven on the
// falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_huffman_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        gv0, gv1, gv2;
    logic [7:0]  gd0, gd1, gd2;

    logic        cntv0, cv0;
    logic [31:0] cnt0, hc0, m0;
    logic        cntv1, cv1;
    logic [15:0] cnt1, hc1, m1;
    logic        cntv2, cv2;
    logic [15:0] cnt2;
    logic [31:0] hc2, m2;

    int vecs = 0;
    int errs = 0;

    huffman_gen #(.NSYM(4), .CNT_W(8), .CODE_W(8)) u_d0 (
        .clk(clk), .reset(reset), .gray_valid(gv0), .gray_data(gd0),
        .CNT_valid(cntv0), .CNT(cnt0), .code_valid(cv0), .HC(hc0), .M(m0)
    );

    huffman_gen #(.NSYM(2), .CNT_W(8), .CODE_W(8)) u_d1 (
        .clk(clk), .reset(reset), .gray_valid(gv1), .gray_data(gd1),
        .CNT_valid(cntv1), .CNT(cnt1), .code_valid(cv1), .HC(hc1), .M(m1)
    );

    huffman_gen #(.NSYM(4), .CNT_W(4), .CODE_W(8)) u_d2 (
        .clk(clk), .reset(reset), .gray_valid(gv2), .gray_data(gd2),
        .CNT_valid(cntv2), .CNT(cnt2), .code_valid(cv2), .HC(hc2), .M(m2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [7:0] data);
        case (d)
            0:       begin gv0 = v; gd0 = data; end
            1:       begin gv1 = v; gd1 = data; end
            default: begin gv2 = v; gd2 = data; end
        endcase
    endtask

    function automatic logic cvalid(input int d);
        case (d)
            0:       return cv0;
            1:       return cv1;
            default: return cv2;
        endcase
    endfunction

    // n samples of symbol sym, one per cycle
    task automatic send(input int d, input int sym, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive(d, 1'b1, 8'(sym));
        end
    endtask

    // Called at the negedge of the REPORT cycle (T+0 sampled as start);
    // checks that code_valid first appears exactly exp_lat cycles after T.
    task automatic wait_code(input int d, input int start, input int exp_lat, input string tag);
        int lat;
        lat = start;
        while ((cvalid(d) !== 1'b1) && (lat < 60)) begin
            @(negedge clk);
            lat++;
        end
        chk(tag, 64'(lat), 64'(exp_lat));
    endtask

    // Basic-code scenario on d0: counts {5,1,1,1}.
    task automatic run_basic(input string pfx);
        send(0, 1, 5);
        send(0, 2, 1);
        send(0, 3, 1);
        send(0, 4, 1);
        @(negedge clk);
        chk({pfx, "_cnt_live"}, 64'(cnt0), 64'h01010105);
        chk({pfx, "_cntv_low"}, 64'(cntv0), 64'd0);
        drive(0, 1'b0, 8'd0);
        @(negedge clk);
        chk({pfx, "_cntv"}, 64'(cntv0), 64'd1);
        chk({pfx, "_cnt"}, 64'(cnt0), 64'h01010105);
        chk({pfx, "_cv_at_T"}, 64'(cv0), 64'd0);
        @(negedge clk);
        chk({pfx, "_cntv_pulse"}, 64'(cntv0), 64'd0);
        wait_code(0, 1, 10, {pfx, "_lat"});
        chk({pfx, "_hc"}, 64'(hc0), 64'h05040300);
        chk({pfx, "_m"}, 64'(m0), 64'h07070301);
    endtask

    initial begin
        reset = 1'b1;
        gv0 = 1'b0; gv1 = 1'b0; gv2 = 1'b0;
        gd0 = 8'd0; gd1 = 8'd0; gd2 = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cntv", 64'(cntv0), 64'd0);
        chk("rst_cv", 64'(cv0), 64'd0);
        chk("rst_cnt", 64'(cnt0), 64'd0);
        chk("rst_hc", 64'(hc0), 64'd0);
        chk("rst_m", 64'(m0), 64'd0);
        reset = 1'b0;

        // basic code
        run_basic("basic");

        // tie-break: {3,3}
        send(1, 1, 3);
        send(1, 2, 3);
        @(negedge clk);
        drive(1, 1'b0, 8'd0);
        @(negedge clk);
        chk("tie_cntv", 64'(cntv1), 64'd1);
        chk("tie_cnt", 64'(cnt1), 64'h0303);
        wait_code(1, 0, 4, "tie_lat");
        chk("tie_hc", 64'(hc1), 64'h0100);
        chk("tie_m", 64'(m1), 64'h0101);

        // ignored values and saturation: 20 x sym1, then 0 and 9
        send(2, 1, 20);
        send(2, 0, 1);
        send(2, 9, 1);
        @(negedge clk);
        drive(2, 1'b0, 8'd0);
        @(negedge clk);
        chk("sat_cntv", 64'(cntv2), 64'd1);
        chk("sat_cnt", 64'(cnt2), 64'h000F);
        wait_code(2, 0, 10, "sat_lat");
        chk("sat_hc", 64'(hc2), 64'h07060200);
        chk("sat_m", 64'(m2), 64'h07070301);

        // back-to-back frame on d0 (in DONE): two samples of symbol 2
        @(negedge clk);
        chk("b2b_cv_hold", 64'(cv0), 64'd1);
        drive(0, 1'b1, 8'd2);
        @(negedge clk);
        chk("b2b_cv_drop", 64'(cv0), 64'd0);
        chk("b2b_cnt_restart", 64'(cnt0), 64'h00000100);
        chk("b2b_hc_clr", 64'(hc0), 64'd0);
        drive(0, 1'b1, 8'd2);
        @(negedge clk);
        drive(0, 1'b0, 8'd0);
        @(negedge clk);
        chk("b2b_cntv", 64'(cntv0), 64'd1);
        chk("b2b_cnt", 64'(cnt0), 64'h00000200);
        wait_code(0, 0, 10, "b2b_lat");
        chk("b2b_hc", 64'(hc0), 64'h07060002);
        chk("b2b_m", 64'(m0), 64'h07070103);

        // reset during SEL2 of a basic frame
        send(0, 1, 5);
        send(0, 2, 1);
        send(0, 3, 1);
        send(0, 4, 1);
        @(negedge clk);
        drive(0, 1'b0, 8'd0);
        @(negedge clk);
        chk("mid_cntv", 64'(cntv0), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_cntv", 64'(cntv0), 64'd0);
        chk("mid_rst_cv", 64'(cv0), 64'd0);
        chk("mid_rst_cnt", 64'(cnt0), 64'd0);
        chk("mid_rst_hc", 64'(hc0), 64'd0);
        chk("mid_rst_m", 64'(m0), 64'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_idle_cv", 64'(cv0), 64'd0);

        // fresh frame after reset gives the basic result again
        run_basic("again");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
